// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage and the writeback stage, including the
// register-file write port and the upstream stall handshake.
interface writeback_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFS_W      = 2
);
    logic                  stall;
    logic                  flush;
    logic                  in_valid;
    logic                  mem_done;
    logic [XLEN-1:0]       data_mem;
    logic [XLEN-1:0]       result_alu;
    logic [XLEN-1:0]       pc_plus4;
    logic [1:0]            WbSel;
    logic [2:0]            MemFunct3;
    logic [OFS_W-1:0]      addr_lo;
    logic                  in_RegWrite;
    logic [REG_ADDR_W-1:0] in_RegDest;
    logic                  in_PCSrc;

    logic [XLEN-1:0]       data_wb;
    logic                  out_RegWrite;
    logic [REG_ADDR_W-1:0] out_RegDest;
    logic                  out_PCSrc;
    logic                  out_valid;
    logic                  busy;

    modport master (
        output stall, flush, in_valid, mem_done, data_mem, result_alu, pc_plus4,
               WbSel, MemFunct3, addr_lo, in_RegWrite, in_RegDest, in_PCSrc,
        input  data_wb, out_RegWrite, out_RegDest, out_PCSrc, out_valid, busy
    );

    modport slave (
        input  stall, flush, in_valid, mem_done, data_mem, result_alu, pc_plus4,
               WbSel, MemFunct3, addr_lo, in_RegWrite, in_RegDest, in_PCSrc,
        output data_wb, out_RegWrite, out_RegDest, out_PCSrc, out_valid, busy
    );
endinterface

// File: rtl/writeback_stage.sv
// Pipeline writeback stage: holds one retiring instruction, waits on slow
// loads, extends sub-word load data and drives the register-file write port.
module writeback_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFS_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    writeback_stage_if.slave   wb
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

    localparam logic [OFS_W-1:0] HALF_MASK = ~OFS_W'(1);
    localparam logic [OFS_W-1:0] WORD_MASK = ~OFS_W'(3);

    state_t                state, next_state;
    logic                  can_capture;
    logic                  capture_load;

    logic                  is_load_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       ld_buf;
    logic [2:0]            funct3_q;
    logic [OFS_W-1:0]      addr_q;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] reg_dest_q;
    logic                  pc_src_q;

    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_word;
    logic [XLEN-1:0]       load_data;

    assign can_capture  = (state != S_WAIT) & ~wb.stall & wb.in_valid & ~wb.flush;
    assign capture_load = wb.WbSel == 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_WAIT: begin
                if (wb.flush)
                    next_state = S_IDLE;
                else if (wb.mem_done)
                    next_state = S_COMMIT;
            end
            default: begin
                if (can_capture)
                    next_state = (capture_load && !wb.mem_done) ? S_WAIT : S_COMMIT;
                else
                    next_state = S_IDLE;
            end
        endcase
    end

    // Link value is folded into alu_q at capture so retirement needs only one mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_load_q   <= 1'b0;
            alu_q       <= '0;
            ld_buf      <= '0;
            funct3_q    <= '0;
            addr_q      <= '0;
            reg_write_q <= 1'b0;
            reg_dest_q  <= '0;
            pc_src_q    <= 1'b0;
        end else if (can_capture) begin
            is_load_q   <= capture_load;
            alu_q       <= (wb.WbSel == 2'd2) ? wb.pc_plus4 : wb.result_alu;
            funct3_q    <= wb.MemFunct3;
            addr_q      <= wb.addr_lo;
            reg_write_q <= wb.in_RegWrite;
            reg_dest_q  <= wb.in_RegDest;
            pc_src_q    <= wb.in_PCSrc;
            if (capture_load && wb.mem_done)
                ld_buf <= wb.data_mem;
        end else if (state == S_WAIT && wb.mem_done && !wb.flush) begin
            ld_buf <= wb.data_mem;
        end
    end

    // Masking the offset gives natural half/word alignment for any XLEN.
    always_comb begin
        ld_byte   = ld_buf[{addr_q, 3'b000} +: 8];
        ld_half   = ld_buf[{addr_q & HALF_MASK, 3'b000} +: 16];
        ld_word   = ld_buf[{addr_q & WORD_MASK, 3'b000} +: 32];
        load_data = ld_buf;
        case (funct3_q)
            3'b000:  load_data = XLEN'($signed(ld_byte));
            3'b100:  load_data = XLEN'(ld_byte);
            3'b001:  load_data = XLEN'($signed(ld_half));
            3'b101:  load_data = XLEN'(ld_half);
            3'b010:  load_data = XLEN'($signed(ld_word));
            3'b110:  load_data = XLEN'(ld_word);
            default: load_data = ld_buf;
        endcase
    end

    always_comb begin
        wb.out_valid    = state == S_COMMIT;
        wb.busy         = state == S_WAIT;
        wb.out_RegDest  = (state != S_IDLE) ? reg_dest_q : '0;
        wb.out_PCSrc    = (state != S_IDLE) ? pc_src_q : 1'b0;
        wb.out_RegWrite = wb.out_valid & reg_write_q & (reg_dest_q != '0);
        wb.data_wb      = '0;
        if (wb.out_valid)
            wb.data_wb = is_load_q ? load_data : alu_q;
    end
endmodule
